// File: rtl/tx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_arb_pkg
//  Description : Shared constants and helpers for the TX packet arbiter:
//                flag bit positions, one-hot FSM state encoding and the
//                flag word sent to the MAC when a stalled packet is aborted.
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_arb_pkg;

   // Bit positions inside the 4-bit framing flags
   localparam int FLAG_SOF = 0;
   localparam int FLAG_EOF = 1;

   // One-hot FSM state encoding
   localparam int         ST_W      = 5;
   localparam logic [4:0] S_IDLE    = 5'b00001;
   localparam logic [4:0] S_GRANT   = 5'b00010;
   localparam logic [4:0] S_PASS    = 5'b00100;
   localparam logic [4:0] S_ABORT   = 5'b01000;
   localparam logic [4:0] S_DISCARD = 5'b10000;

   // EOF-only word used to close a truncated frame towards the MAC
   localparam logic [3:0] ABORT_FLAGS = 4'b0010;

   // Encode a one-hot vector (up to 8 sources) into a binary index
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tx_packet_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Rotates the request
//                vector so the search starts just after the last winner,
//                isolates the lowest set bit, then rotates back. Rotation
//                uses a doubled vector so no modulo arithmetic is needed.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_SRC = 3,
   parameter int IDX_W   = $clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] i_req,
   input  logic [IDX_W-1:0]   i_last,
   output logic [NUM_SRC-1:0] o_pick,
   output logic               o_valid
);

   logic [IDX_W:0]     w_shift;
   logic [NUM_SRC-1:0] w_rot;
   logic [NUM_SRC-1:0] w_first;

   // Search starts one past the previous winner; a shift of NUM_SRC is identity
   assign w_shift = {1'b0, i_last} + (IDX_W+1)'(1);

   // Rotate right by w_shift so the preferred source lands at bit 0
   assign w_rot   = NUM_SRC'({i_req, i_req} >> w_shift);

   // Lowest set bit of the rotated vector is the winner
   assign w_first = w_rot & (~w_rot + NUM_SRC'(1));

   // Rotate the winner back left by the same amount
   assign o_pick  = NUM_SRC'(({w_first, w_first} << w_shift) >> NUM_SRC);

   assign o_valid = |i_req;

endmodule
`default_nettype wire

// File: rtl/tx_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tx_packet_arbiter
//  Description : Shares the MAC TX framed 32-bit port between NUM_SRC packet
//                sources. Whole packets (SOF..EOF) are granted in round-robin
//                order. A granted source that stalls for TIMEOUT_CYCLES has
//                its frame closed with an EOF-only word and the remainder of
//                its packet is dropped, so one stuck source cannot lock the MAC.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_packet_arbiter
   import tx_arb_pkg::*;
#(
   parameter int NUM_SRC        = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4*NUM_SRC-1:0]   req_flags_i,
   input  logic [32*NUM_SRC-1:0]  req_data_i,
   input  logic [NUM_SRC-1:0]     req_src_rdy_i,
   output logic [NUM_SRC-1:0]     req_dst_rdy_o,
   output logic [3:0]             wr_flags_o,
   output logic [31:0]            wr_data_o,
   output logic                   wr_src_rdy_o,
   input  logic                   wr_dst_rdy_i,
   output logic [NUM_SRC-1:0]     grant_o,
   output logic                   busy_o,
   output logic                   abort_o,
   output logic                   stray_o
);

   localparam int             IDX_W    = $clog2(NUM_SRC);
   localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [ST_W-1:0]    r_state;
   logic [ST_W-1:0]    w_next_state;
   logic [IDX_W-1:0]   r_owner;
   logic [IDX_W-1:0]   r_last;
   logic [CNT_W-1:0]   r_cnt;

   logic [NUM_SRC-1:0] w_elig;
   logic [NUM_SRC-1:0] w_pick;
   logic               w_pick_valid;
   logic [IDX_W-1:0]   w_pick_idx;
   logic [NUM_SRC-1:0] w_own_oh;
   logic [3:0]         w_own_flags;
   logic [31:0]        w_own_data;
   logic               w_own_rdy;
   logic               w_xfer;
   logic               w_eof_xfer;
   logic               w_timeout;
   logic               w_drop_eof;

   // A source may win arbitration only while it presents a SOF word
   generate
      for (genvar g = 0; g < NUM_SRC; g++) begin : g_elig
         assign w_elig[g] = req_src_rdy_i[g] & req_flags_i[4*g + FLAG_SOF];
      end
   endgenerate

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .i_req   (w_elig),
      .i_last  (r_last),
      .o_pick  (w_pick),
      .o_valid (w_pick_valid)
   );

   assign w_pick_idx  = IDX_W'(onehot_to_idx(8'(w_pick)));
   assign w_own_oh    = {{(NUM_SRC-1){1'b0}}, 1'b1} << r_owner;
   assign w_own_flags = req_flags_i[4*r_owner +: 4];
   assign w_own_data  = req_data_i[32*r_owner +: 32];
   assign w_own_rdy   = req_src_rdy_i[r_owner];

   assign w_xfer      = (r_state == S_PASS) && w_own_rdy && wr_dst_rdy_i;
   assign w_eof_xfer  = w_xfer && w_own_flags[FLAG_EOF];
   // Terminal count only fires on a genuine idle cycle; an EOF transfer
   // needs the source ready, so it always takes priority over an abort
   assign w_timeout   = (r_state == S_PASS) && (r_cnt == CNT_TERM) &&
                        !w_own_rdy && wr_dst_rdy_i;
   assign w_drop_eof  = (r_state == S_DISCARD) && w_own_rdy &&
                        w_own_flags[FLAG_EOF];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (w_pick_valid) w_next_state = S_GRANT;
         S_GRANT:   w_next_state = S_PASS;
         S_PASS: begin
            if (w_eof_xfer)     w_next_state = S_IDLE;
            else if (w_timeout) w_next_state = S_ABORT;
         end
         S_ABORT:   if (wr_dst_rdy_i) w_next_state = S_DISCARD;
         S_DISCARD: if (w_drop_eof)   w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // Owner captured at arbitration; last updated when a packet fully ends
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner <= '0;
         r_last  <= IDX_W'(NUM_SRC - 1);
      end else begin
         if ((r_state == S_IDLE) && w_pick_valid) r_owner <= w_pick_idx;
         if (w_eof_xfer || w_drop_eof)            r_last  <= r_owner;
      end
   end

   // Stall counter: counts only cycles where the owner is idle and the MAC is ready
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if ((r_state != S_PASS) || w_xfer || !wr_dst_rdy_i) begin
         r_cnt <= '0;
      end else if (!w_own_rdy && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Output decode and data-path mux
   always_comb begin
      req_dst_rdy_o = '0;
      wr_flags_o    = '0;
      wr_data_o     = '0;
      wr_src_rdy_o  = 1'b0;
      abort_o       = 1'b0;
      stray_o       = 1'b0;
      busy_o        = (r_state != S_IDLE);
      grant_o       = (r_state != S_IDLE) ? w_own_oh : '0;
      case (r_state)
         S_IDLE: begin
            // With no SOF anywhere, every ready source holds a stray word
            if (!w_pick_valid && !reset) begin
               req_dst_rdy_o = req_src_rdy_i;
               stray_o       = |req_src_rdy_i;
            end
         end
         S_PASS: begin
            wr_flags_o             = w_own_flags;
            wr_data_o              = w_own_data;
            wr_src_rdy_o           = w_own_rdy;
            req_dst_rdy_o[r_owner] = wr_dst_rdy_i;
            abort_o                = w_timeout;
         end
         S_ABORT: begin
            wr_flags_o   = ABORT_FLAGS;
            wr_src_rdy_o = 1'b1;
         end
         S_DISCARD: begin
            req_dst_rdy_o[r_owner] = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_tx_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_packet_arbiter
//  Description : Directed self-checking bench for tx_packet_arbiter
//                (NUM_SRC=3, TIMEOUT_CYCLES=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_packet_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] flags;
   logic [95:0] data;
   logic [2:0]  srdy;
   logic        wdst;
   logic [2:0]  dst_rdy;
   logic [3:0]  wr_flags;
   logic [31:0] wr_data;
   logic        wr_src_rdy;
   logic [2:0]  grant;
   logic        busy, abort_p, stray_p;

   int n_tests = 0;
   int n_fail  = 0;
   int pk[3], wi[3], ek[3];
   int order[4] = '{0, 1, 2, 0};
   logic saw_abort;

   tx_packet_arbiter #(.NUM_SRC(3), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .req_flags_i(flags), .req_data_i(data),
      .req_src_rdy_i(srdy), .req_dst_rdy_o(dst_rdy),
      .wr_flags_o(wr_flags), .wr_data_o(wr_data),
      .wr_src_rdy_o(wr_src_rdy), .wr_dst_rdy_i(wdst),
      .grant_o(grant), .busy_o(busy), .abort_o(abort_p), .stray_o(stray_p)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int i, input logic [3:0] f, input logic [31:0] d, input logic r);
      flags[4*i +: 4]  = f;
      data[32*i +: 32] = d;
      srdy[i]          = r;
   endtask

   function automatic logic [31:0] wdat(input int i, input int p, input int w);
      return 32'hA000_0000 | 32'(i << 16) | 32'(p << 8) | 32'(w);
   endfunction

   task automatic drive_model();
      for (int i = 0; i < 3; i++)
         set_src(i, (wi[i] != 0) ? 4'b0010 : 4'b0001, wdat(i, pk[i], wi[i]), 1'b1);
   endtask

   // One cycle of the continuously-requesting source model
   task automatic cyc();
      logic [2:0] acc;
      acc = dst_rdy & srdy;
      tick();
      for (int i = 0; i < 3; i++) begin
         if (acc[i]) begin
            if (wi[i] == 0) wi[i] = 1;
            else begin wi[i] = 0; pk[i]++; end
         end
      end
      drive_model();
      #1;
   endtask

   initial begin
      reset = 1'b1; flags = '0; data = '0; srdy = '0; wdst = 1'b1;
      // ---------------- reset state, stray word present during reset
      set_src(1, 4'b0000, 32'h1234_5678, 1'b1);
      tick(); #1;
      chk("rst_grant",   32'(grant), 0);
      chk("rst_busy",    32'(busy), 0);
      chk("rst_wsrc",    32'(wr_src_rdy), 0);
      chk("rst_wflags",  32'(wr_flags), 0);
      chk("rst_wdata",   wr_data, 0);
      chk("rst_dstrdy",  32'(dst_rdy), 0);
      chk("rst_stray",   32'(stray_p), 0);
      chk("rst_abort",   32'(abort_p), 0);
      set_src(1, 4'b0000, 32'h0, 1'b0);
      tick(); reset = 1'b0;

      // ---------------- test 1: src1 3-word packet
      set_src(1, 4'b0001, 32'h1111_0001, 1'b1); #1;
      chk("t1_idle_dst", 32'(dst_rdy), 0);
      chk("t1_idle_busy", 32'(busy), 0);
      tick(); #1;
      chk("t1_grant", 32'(grant), 'h2);
      chk("t1_grant_wsrc", 32'(wr_src_rdy), 0);
      tick(); #1;
      chk("t1_w1_data", wr_data, 32'h1111_0001);
      chk("t1_w1_flags", 32'(wr_flags), 'h1);
      chk("t1_w1_dst", 32'(dst_rdy), 'h2);
      tick(); set_src(1, 4'b0000, 32'h1111_0002, 1'b1); #1;
      chk("t1_w2_data", wr_data, 32'h1111_0002);
      tick(); set_src(1, 4'b0010, 32'h1111_0003, 1'b1); #1;
      chk("t1_w3_data", wr_data, 32'h1111_0003);
      chk("t1_w3_busy", 32'(busy), 1);
      tick(); set_src(1, 4'b0000, 32'h0, 1'b0); #1;
      chk("t1_busy_fall", 32'(busy), 0);
      chk("t1_grant_clr", 32'(grant), 0);

      // ---------------- test 2: all sources continuously, from reset
      reset = 1'b1;
      tick(); reset = 1'b0;
      for (int i = 0; i < 3; i++) begin pk[i] = 0; wi[i] = 0; ek[i] = 0; end
      drive_model(); #1;
      for (int p = 0; p < 4; p++) begin
         int s;
         s = order[p];
         chk("t2_idle_busy", 32'(busy), 0);
         cyc();
         chk("t2_grant", 32'(grant), 32'(1 << s));
         cyc();
         chk("t2_w0_data", wr_data, wdat(s, ek[s], 0));
         chk("t2_w0_flags", 32'(wr_flags), 'h1);
         chk("t2_w0_dst", 32'(dst_rdy), 32'(1 << s));
         cyc();
         chk("t2_w1_data", wr_data, wdat(s, ek[s], 1));
         chk("t2_w1_flags", 32'(wr_flags), 'h2);
         ek[s]++;
         cyc();
         if (p == 3) begin srdy = '0; #1; end
      end
      chk("t2_end_busy", 32'(busy), 0);

      // ---------------- test 3: src0 stalls -> timeout abort (last=0)
      tick(); set_src(0, 4'b0001, 32'hC000_0001, 1'b1); #1;
      tick(); set_src(2, 4'b0001, 32'hC200_0001, 1'b1); #1;
      chk("t3_grant", 32'(grant), 'h1);
      tick(); #1;
      chk("t3_sof_data", wr_data, 32'hC000_0001);
      tick(); set_src(0, 4'b0000, 32'hC000_0002, 1'b0); #1;
      for (int k = 1; k < 8; k++) begin
         chk("t3_no_abort_early", 32'(abort_p), 0);
         tick(); #1;
      end
      chk("t3_abort_pulse", 32'(abort_p), 1);
      tick(); wdst = 1'b0; #1;
      chk("t3_abort_flags", 32'(wr_flags), 'h2);
      chk("t3_abort_data", wr_data, 0);
      chk("t3_abort_wsrc", 32'(wr_src_rdy), 1);
      chk("t3_abort_dst", 32'(dst_rdy), 0);
      chk("t3_abort_single", 32'(abort_p), 0);
      tick(); wdst = 1'b1; #1;
      chk("t3_abort_hold", 32'(wr_flags), 'h2);
      tick(); set_src(0, 4'b0000, 32'hC000_0002, 1'b1); #1;
      chk("t3_disc_dst", 32'(dst_rdy), 'h1);
      chk("t3_disc_wsrc", 32'(wr_src_rdy), 0);
      tick(); set_src(0, 4'b0000, 32'hC000_0003, 1'b1); #1;
      chk("t3_disc_w3", 32'(wr_src_rdy), 0);
      tick(); set_src(0, 4'b0010, 32'hC000_0004, 1'b1); #1;
      chk("t3_disc_eof_flags", 32'(wr_flags), 0);
      tick(); set_src(0, 4'b0000, 32'h0, 1'b0); #1;
      chk("t3_idle_busy", 32'(busy), 0);
      tick(); #1;
      chk("t3_src2_grant", 32'(grant), 'h4);
      tick(); #1;
      chk("t3_src2_data", wr_data, 32'hC200_0001);
      tick(); set_src(2, 4'b0010, 32'hC200_0002, 1'b1); #1;
      chk("t3_src2_eof", wr_data, 32'hC200_0002);
      tick(); set_src(2, 4'b0000, 32'h0, 1'b0); #1;
      chk("t3_src2_done", 32'(busy), 0);

      // ---------------- test 4: MAC back-pressure 2000 cycles (last=2)
      set_src(1, 4'b0001, 32'h4444_0001, 1'b1);
      tick(); tick(); #1;
      chk("t4_sof_data", wr_data, 32'h4444_0001);
      tick(); set_src(1, 4'b0000, 32'h4444_0002, 1'b1); wdst = 1'b0;
      saw_abort = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         srdy[1] = (k < 1000);
         #1;
         if (abort_p) saw_abort = 1'b1;
         tick();
      end
      srdy[1] = 1'b1; wdst = 1'b1; #1;
      chk("t4_no_abort", 32'(saw_abort), 0);
      chk("t4_busy", 32'(busy), 1);
      chk("t4_w2_data", wr_data, 32'h4444_0002);
      chk("t4_w2_wsrc", 32'(wr_src_rdy), 1);
      tick(); set_src(1, 4'b0010, 32'h4444_0003, 1'b1); #1;
      chk("t4_eof_data", wr_data, 32'h4444_0003);
      tick(); set_src(1, 4'b0000, 32'h0, 1'b0); #1;
      chk("t4_done", 32'(busy), 0);

      // ---------------- test 5: stray word + single-word packet (last=1)
      set_src(2, 4'b0000, 32'hDEAD_BEEF, 1'b1);
      set_src(0, 4'b0011, 32'h5000_0001, 1'b1); #1;
      chk("t5_no_flush", 32'(dst_rdy), 0);
      chk("t5_no_stray", 32'(stray_p), 0);
      tick(); #1;
      chk("t5_grant", 32'(grant), 'h1);
      tick(); #1;
      chk("t5_single_flags", 32'(wr_flags), 'h3);
      chk("t5_single_data", wr_data, 32'h5000_0001);
      tick(); set_src(0, 4'b0000, 32'h0, 1'b0); #1;
      chk("t5_idle_busy", 32'(busy), 0);
      chk("t5_stray", 32'(stray_p), 1);
      chk("t5_flush_dst", 32'(dst_rdy), 'h4);
      tick(); set_src(2, 4'b0000, 32'h0, 1'b0); #1;
      chk("t5_stray_once", 32'(stray_p), 0);

      // ---------------- test 5b: EOF on the terminal-count cycle (last=0)
      set_src(1, 4'b0001, 32'h6666_0001, 1'b1);
      tick(); tick();
      tick(); set_src(1, 4'b0000, 32'h0, 1'b0);
      for (int j = 0; j < 6; j++) tick();
      tick(); set_src(1, 4'b0010, 32'h6666_0002, 1'b1); #1;
      chk("t5b_eof_no_abort", 32'(abort_p), 0);
      chk("t5b_eof_flags", 32'(wr_flags), 'h2);
      tick(); set_src(1, 4'b0000, 32'h0, 1'b0); #1;
      chk("t5b_done", 32'(busy), 0);
      chk("t5b_after_abort", 32'(abort_p), 0);

      // ---------------- test 6: async reset mid-packet (last=1)
      set_src(2, 4'b0001, 32'h7777_0001, 1'b1);
      tick(); tick();
      tick(); set_src(2, 4'b0000, 32'h7777_0002, 1'b1); #1;
      chk("t6_w2_data", wr_data, 32'h7777_0002);
      #1; reset = 1'b1; #1;
      chk("t6_rst_grant", 32'(grant), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_wsrc", 32'(wr_src_rdy), 0);
      chk("t6_rst_wdata", wr_data, 0);
      chk("t6_rst_dst", 32'(dst_rdy), 0);
      set_src(2, 4'b0000, 32'h0, 1'b0);
      tick(); reset = 1'b0;
      set_src(1, 4'b0001, 32'h7878_0001, 1'b1); #1;
      chk("t6_idle", 32'(busy), 0);
      tick(); #1;
      chk("t6_regrant", 32'(grant), 'h2);
      tick(); #1;
      chk("t6_data", wr_data, 32'h7878_0001);
      chk("t6_dst", 32'(dst_rdy), 'h2);
      tick(); set_src(1, 4'b0010, 32'h7878_0002, 1'b1);
      tick(); set_src(1, 4'b0000, 32'h0, 1'b0); #1;
      chk("t6_done", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
